// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: 3-stage pipelined Urdhva-Tiryagbhyam multiplier for MUL/MULH/MULHSU/MULHU.
// Define VEDIC_MUL_FLUSH_EN to add the synchronous pipeline flush port.
module vedic_mul_pipe #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
`ifdef VEDIC_MUL_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result
);

  localparam int unsigned H  = N / 2;
  localparam int unsigned PW = 2 * N;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic flush_i;
`ifdef VEDIC_MUL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // All stages move together; a stalled output freezes the whole pipe.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // S1 stage registers
  logic         v1;
  logic [1:0]   op1;
  logic         neg1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;

  // S2 stage registers
  logic         v2;
  logic [1:0]   op2;
  logic         neg2;
  logic [N-1:0] ll;
  logic [N-1:0] hl;
  logic [N-1:0] lh;
  logic [N-1:0] hh;

  // S1: sign conditioning into magnitudes
  logic         sa_c;
  logic         sb_c;
  logic [N-1:0] ma_c;
  logic [N-1:0] mb_c;
  logic         neg_c;

  always_comb begin
    sa_c  = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[N-1];
    sb_c  = (in_op == OP_MULH) && in_b[N-1];
    ma_c  = sa_c ? (~in_a + N'(1)) : in_a;
    mb_c  = sb_c ? (~in_b + N'(1)) : in_b;
    // a zero magnitude never yields a negated product
    neg_c = (sa_c ^ sb_c) && (ma_c != '0) && (mb_c != '0);
  end

  // S2: four vertical/crosswise half-width sub-products
  logic [N-1:0] ll_c;
  logic [N-1:0] hl_c;
  logic [N-1:0] lh_c;
  logic [N-1:0] hh_c;

  always_comb begin
    ll_c = N'(a1[H-1:0]) * N'(b1[H-1:0]);
    hl_c = N'(a1[N-1:H]) * N'(b1[H-1:0]);
    lh_c = N'(a1[H-1:0]) * N'(b1[N-1:H]);
    hh_c = N'(a1[N-1:H]) * N'(b1[N-1:H]);
  end

  // S3: combine, sign fix, half select
  logic [PW-1:0] mid_c;
  logic [PW-1:0] prod_c;
  logic [N-1:0]  res_c;

  always_comb begin
    mid_c  = PW'(hl) + PW'(lh);
    prod_c = {hh, ll} + (mid_c << H);
    if (neg2) begin
      prod_c = ~prod_c + PW'(1);
    end
    res_c = (op2 == OP_MUL) ? prod_c[N-1:0] : prod_c[PW-1:N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush_i) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1        <= '0;
      neg1       <= 1'b0;
      a1         <= '0;
      b1         <= '0;
      op2        <= '0;
      neg2       <= 1'b0;
      ll         <= '0;
      hl         <= '0;
      lh         <= '0;
      hh         <= '0;
      out_result <= '0;
    end else if (adv) begin
      op1        <= in_op;
      neg1       <= neg_c;
      a1         <= ma_c;
      b1         <= mb_c;
      op2        <= op1;
      neg2       <= neg1;
      ll         <= ll_c;
      hl         <= hl_c;
      lh         <= lh_c;
      hh         <= hh_c;
      out_result <= res_c;
    end
  end

endmodule
